// File: rtl/carrier_nco_if.sv
// Control and carrier-output bundle between the UI register block (master) and carrier_nco (slave).
// wave_sel is present only when CARRIER_NCO_TRI_EN is defined.
interface carrier_nco_if #(
    parameter int PHASE_W = 24
);
    logic               sample_tick;
    logic               enable;
    logic [PHASE_W-1:0] freq_word;
    logic               freq_load;
    logic signed [31:0] sin;
    logic               sin_valid;
    logic               phase_wrap;

`ifdef CARRIER_NCO_TRI_EN
    logic               wave_sel;

    modport master (
        output sample_tick, enable, freq_word, freq_load, wave_sel,
        input  sin, sin_valid, phase_wrap
    );
    modport slave (
        input  sample_tick, enable, freq_word, freq_load, wave_sel,
        output sin, sin_valid, phase_wrap
    );
`else
    modport master (
        output sample_tick, enable, freq_word, freq_load,
        input  sin, sin_valid, phase_wrap
    );
    modport slave (
        input  sample_tick, enable, freq_word, freq_load,
        output sin, sin_valid, phase_wrap
    );
`endif
endinterface

// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator, quarter-wave sine ROM and quadrant folding into a small signed carrier.
// Optional triangle waveform (wave_sel) is built when CARRIER_NCO_TRI_EN is defined.
module carrier_nco #(
    parameter int PHASE_W  = 24,
    parameter int LUT_AW   = 8,
    parameter int OUT_FRAC = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    carrier_nco_if.slave bus
);
    localparam int LUT_N = 2 ** LUT_AW;
    localparam int SHIFT = 15 - OUT_FRAC;

    // round(32767*sin(pi/2*(idx+0.5)/LUT_N)) via a Q30 Taylor series, evaluated at elaboration only.
    function automatic logic [15:0] lut_entry(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (64'sd1686629713 * longint'(2 * idx + 1)) >>> (LUT_AW + 1);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            acc  = acc + term;
        end
        return 16'((acc * 32767 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    // NOTE: the ROM is pure constants, so it needs no reset and no clocked write path.
    logic [15:0] lut_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic [15:0] ENTRY = lut_entry(g);
        assign lut_rom[g] = ENTRY;
    end

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] active_inc;
    logic [PHASE_W-1:0] shadow_inc;
    logic [PHASE_W-1:0] next_shadow;
    logic               pending;
    logic [PHASE_W:0]   phase_sum;
    logic               tick_go;
    logic               wrap_tick;
    logic               commit;

    assign tick_go     = bus.sample_tick & bus.enable;
    assign phase_sum   = {1'b0, phase} + {1'b0, active_inc};
    assign wrap_tick   = tick_go & phase_sum[PHASE_W];
    assign next_shadow = bus.freq_load ? bus.freq_word : shadow_inc;
    // A load landing on a wrapping tick commits straight away; that tick still used the old increment.
    assign commit      = (pending | bus.freq_load) & ((active_inc == '0) | wrap_tick);

    // NOTE: every clocked block uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_inc <= '0;
            active_inc <= '0;
            pending    <= 1'b0;
        end else begin
            shadow_inc <= next_shadow;
            if (commit) begin
                active_inc <= next_shadow;
                pending    <= 1'b0;
            end else if (bus.freq_load) begin
                pending    <= 1'b1;
            end
        end
    end

    logic [1:0]        quad;
    logic [LUT_AW-1:0] a_idx;
    logic [LUT_AW-1:0] addr;
    logic [15:0]       mag;
`ifdef CARRIER_NCO_TRI_EN
    logic [15:0]       tri_ramp;
`endif

    // NOTE: every always_comb output gets a value before any condition, so no latch can form.
    always_comb begin
        quad  = phase[PHASE_W-1 -: 2];
        a_idx = phase[PHASE_W-3 -: LUT_AW];
        addr  = quad[0] ? ~a_idx : a_idx;
        mag   = lut_rom[addr];
`ifdef CARRIER_NCO_TRI_EN
        // Magnitude kept within 15 bits so the negative half never overflows the 17-bit negate.
        tri_ramp = {1'b0, a_idx, {(15 - LUT_AW){1'b0}}};
        if (bus.wave_sel) begin
            mag = quad[0] ? (16'h7FFF - tri_ramp) : tri_ramp;
        end
`endif
    end

    logic               s1_valid;
    logic               s1_wrap;
    logic               s2_valid;
    logic               s2_wrap;
    logic               s2_neg;
    logic [15:0]        s2_mag;
    logic signed [16:0] s3_val;
    logic signed [31:0] sin_next;
    logic signed [31:0] sin_q;
    logic               sin_valid_q;
    logic               phase_wrap_q;

    assign s3_val   = s2_neg ? -$signed({1'b0, s2_mag}) : $signed({1'b0, s2_mag});
    assign sin_next = 32'(s3_val >>> SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase        <= '0;
            s1_valid     <= 1'b0;
            s1_wrap      <= 1'b0;
            s2_valid     <= 1'b0;
            s2_wrap      <= 1'b0;
            s2_neg       <= 1'b0;
            s2_mag       <= '0;
            sin_q        <= '0;
            sin_valid_q  <= 1'b0;
            phase_wrap_q <= 1'b0;
        end else if (!bus.enable) begin
            phase        <= '0;
            s1_valid     <= 1'b0;
            s1_wrap      <= 1'b0;
            s2_valid     <= 1'b0;
            s2_wrap      <= 1'b0;
            s2_neg       <= 1'b0;
            s2_mag       <= '0;
            sin_q        <= '0;
            sin_valid_q  <= 1'b0;
            phase_wrap_q <= 1'b0;
        end else begin
            s1_valid <= tick_go;
            s1_wrap  <= wrap_tick;
            if (tick_go) begin
                phase <= phase_sum[PHASE_W-1:0];
            end
            s2_valid     <= s1_valid;
            s2_wrap      <= s1_wrap;
            s2_neg       <= quad[1];
            s2_mag       <= mag;
            sin_valid_q  <= s2_valid;
            phase_wrap_q <= s2_wrap;
            if (s2_valid) begin
                sin_q <= sin_next;
            end
        end
    end

    assign bus.sin        = sin_q;
    assign bus.sin_valid  = sin_valid_q;
    assign bus.phase_wrap = phase_wrap_q;
endmodule

// File: tb/tb_carrier_nco.sv
// Scoreboard bench for carrier_nco: a bench-side phase/frequency model queues expected samples per tick.
module tb_carrier_nco;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        logic signed [31:0] sin;
        logic               wrap;
        int                 cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    int   wrap_seen;
    logic signed [31:0] last_sin;
    exp_t q[$];

    logic [23:0] m_phase;
    logic [23:0] m_active;
    logic [23:0] m_shadow;
    logic        m_pending;

    int exp_a[4] = '{15, -1, -16, 0};

    carrier_nco_if #(.PHASE_W(24)) bus ();

    carrier_nco #(.PHASE_W(24), .LUT_AW(8), .OUT_FRAC(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_sample(input logic [23:0] ph);
        int a;
        int addr;
        int lut;
        int v;
        a    = int'(ph[21:14]);
        addr = ph[22] ? 255 - a : a;
        lut  = int'(32767.0 * $sin(PI / 2.0 * (real'(addr) + 0.5) / 256.0));
        v    = ph[23] ? -lut : lut;
        return v >>> 11;
    endfunction

    // Drives one cycle of inputs and advances the model by the edge that will sample them.
    task automatic drive(input logic tick, input logic load, input logic [23:0] word, input logic en);
        logic [24:0] nxt;
        logic        wrap;
        exp_t        e;
        bus.sample_tick = tick;
        bus.freq_load   = load;
        bus.freq_word   = word;
        bus.enable      = en;
        wrap = 1'b0;
        if (!en) begin
            m_phase = '0;
            q.delete();
        end else if (tick) begin
            nxt     = {1'b0, m_phase} + {1'b0, m_active};
            wrap    = nxt[24];
            m_phase = nxt[23:0];
            e.sin   = model_sample(m_phase);
            e.wrap  = wrap;
            e.cyc   = cyc + 3;
            q.push_back(e);
        end
        if ((m_pending || load) && (m_active == '0 || wrap)) begin
            m_active  = load ? word : m_shadow;
            m_pending = 1'b0;
        end else if (load) begin
            m_pending = 1'b1;
        end
        if (load) m_shadow = word;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 24'h0, 1'b1);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 24'h0, 1'b1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset_n) begin
            last_sin = '0;
        end else begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missing_valid", cyc, e.cyc);
            end
            if (bus.sin_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", bus.sin_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("sin", $signed(bus.sin), e.sin);
                    check("wrap", bus.phase_wrap, e.wrap);
                    check("latency", cyc, e.cyc);
                    if (bus.phase_wrap) wrap_seen++;
                end
                last_sin = bus.sin;
            end else begin
                if (bus.phase_wrap) check("wrap_no_valid", bus.phase_wrap, 0);
                if (!bus.enable) last_sin = '0;
                else check("sin_hold", $signed(bus.sin), last_sin);
            end
        end
    end

    initial begin
        int w0;
        checks    = 0;
        errors    = 0;
        wrap_seen = 0;
        last_sin  = '0;
        m_phase   = '0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        reset_n         = 1'b0;
        bus.sample_tick = 1'b0;
        bus.enable      = 1'b0;
        bus.freq_word   = '0;
        bus.freq_load   = 1'b0;
`ifdef CARRIER_NCO_TRI_EN
        bus.wave_sel    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_sin", $signed(bus.sin), 0);
        check("rst_valid", bus.sin_valid, 0);
        check("rst_wrap", bus.phase_wrap, 0);
        reset_n = 1'b1;
        idle(2);

        // Quarter-turn steps from a stopped oscillator: fixed reference values.
        drive(1'b0, 1'b1, 24'h400000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 24'h0, 1'b1);
            q[$].sin  = exp_a[i];
            q[$].wrap = (i == 3);
            idle(2);
        end
        idle(4);

        // Back-to-back ticks at a 16-sample period after a load that waits for the wrap.
        w0 = wrap_seen;
        drive(1'b0, 1'b1, 24'h100000, 1'b1);
        ticks(4);
        ticks(32);
        idle(5);
        check("wrap_count_b", wrap_seen - w0, 3);

        // Mid-period rate change 0x400000 -> 0x200000.
        drive(1'b0, 1'b1, 24'h400000, 1'b1);
        ticks(16);
        ticks(2);
        drive(1'b1, 1'b1, 24'h200000, 1'b1);
        ticks(5);
        idle(4);

        // Load coincident with the wrapping tick.
        for (int i = 0; i < 64; i++) begin
            if (({1'b0, m_phase} + {1'b0, m_active}) >= 25'h1000000) break;
            drive(1'b1, 1'b0, 24'h0, 1'b1);
        end
        drive(1'b1, 1'b1, 24'h300000, 1'b1);
        ticks(3);

        // Two loads before commit: the later one wins.
        drive(1'b0, 1'b1, 24'h080000, 1'b1);
        drive(1'b0, 1'b1, 24'h040000, 1'b1);
        ticks(24);
        idle(4);

        // Disabled with ticks: silent and zero, then a fresh start at phase=active_inc.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 24'h0, 1'b0);
            check("dis_sin", $signed(bus.sin), 0);
            check("dis_valid", bus.sin_valid, 0);
        end
        drive(1'b1, 1'b0, 24'h0, 1'b1);
        idle(4);

        // Zero increment committed at the next wrap: frozen carrier, no more wraps.
        drive(1'b0, 1'b1, 24'h0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            if (!m_pending) break;
            drive(1'b1, 1'b0, 24'h0, 1'b1);
        end
        idle(5);
        w0 = wrap_seen;
        ticks(6);
        idle(5);
        check("no_wrap_zero", wrap_seen - w0, 0);

        // Asynchronous reset in the middle of a busy pipeline.
        drive(1'b0, 1'b1, 24'h100000, 1'b1);
        idle(1);
        drive(1'b0, 1'b1, 24'h100000, 1'b1);
        ticks(5);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_sin", $signed(bus.sin), 0);
        check("async_rst_valid", bus.sin_valid, 0);
        q.delete();
        m_phase   = '0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 24'h0, 1'b1);
        idle(4);
        drive(1'b0, 1'b1, 24'h400000, 1'b1);
        ticks(1);
        idle(5);

        check("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
